// File: rtl/irf_wr_arbiter_pkg.sv
// irf_wr_arbiter_pkg: shared widths and source IDs for the register-file write arbiter
package irf_wr_arbiter_pkg;
  localparam int IRF_AW = 3;
  localparam int IRF_DW = 8;
  localparam logic IRF_SRC_ALU = 1'b0;
  localparam logic IRF_SRC_MEM = 1'b1;
endpackage

// File: rtl/irf_wr_slot.sv
// irf_wr_slot: one-entry writeback buffer with valid/ready; refills in the cycle it drains
module irf_wr_slot
  import irf_wr_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid,
  input  logic [IRF_AW-1:0] addr,
  input  logic [IRF_DW-1:0] data,
  input  logic              grant,
  output logic              ready,
  output logic              full,
  output logic [IRF_AW-1:0] q_addr,
  output logic [IRF_DW-1:0] q_data
);
  assign ready = !full || grant;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      full   <= 1'b0;
      q_addr <= '0;
      q_data <= '0;
    end else if (valid && ready) begin
      full   <= 1'b1;
      q_addr <= addr;
      q_data <= data;
    end else if (grant) full <= 1'b0;
endmodule

// File: rtl/irf_wr_arbiter.sv
// irf_wr_arbiter: ALU/MEM writeback arbiter driving the register file's one-hot write enable
// IRF_WR_RR_EN selects round-robin for contested different-address writes (else MEM priority)
module irf_wr_arbiter
  import irf_wr_arbiter_pkg::*;
#(
  parameter int NREG = 8,
  parameter int DW   = IRF_DW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [IRF_AW-1:0] alu_addr,
  input  logic [DW-1:0]     alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [IRF_AW-1:0] mem_addr,
  input  logic [DW-1:0]     mem_data,
  input  logic              hold,
  output logic [NREG-1:0]   we,
  output logic [IRF_AW-1:0] waddr,
  output logic [DW-1:0]     wdata,
  output logic              busy
);
  logic              alu_full, mem_full, alu_grant, mem_grant;
  logic              both, same, pick_mem, rr_mem, age_mem;
  logic [IRF_AW-1:0] alu_q_addr, mem_q_addr, g_addr;
  logic [DW-1:0]     alu_q_data, mem_q_data, g_data;

  irf_wr_slot u_alu (
    .clk(clk), .rst_n(rst_n), .valid(alu_valid), .addr(alu_addr), .data(alu_data),
    .grant(alu_grant), .ready(alu_ready), .full(alu_full), .q_addr(alu_q_addr), .q_data(alu_q_data)
  );
  irf_wr_slot u_mem (
    .clk(clk), .rst_n(rst_n), .valid(mem_valid), .addr(mem_addr), .data(mem_data),
    .grant(mem_grant), .ready(mem_ready), .full(mem_full), .q_addr(mem_q_addr), .q_data(mem_q_data)
  );

  assign both      = alu_full && mem_full;
  assign same      = alu_q_addr == mem_q_addr;
  assign pick_mem  = both ? (same ? age_mem : rr_mem) : mem_full;
  assign mem_grant = !hold && mem_full && pick_mem;
  assign alu_grant = !hold && alu_full && !pick_mem;
  assign g_addr    = pick_mem ? mem_q_addr : alu_q_addr;
  assign g_data    = pick_mem ? mem_q_data : alu_q_data;
  assign busy      = alu_full || mem_full;

`ifdef IRF_WR_RR_EN
  logic ptr;
  assign rr_mem = ptr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= IRF_SRC_ALU;
    else if (both && !same && !hold) ptr <= !ptr;
`else
  assign rr_mem = IRF_SRC_MEM;
`endif

  // The slot loaded most recently is the younger one; a simultaneous load leaves MEM older.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) age_mem <= IRF_SRC_MEM;
    else if (alu_valid && alu_ready) age_mem <= 1'b1;
    else if (mem_valid && mem_ready) age_mem <= 1'b0;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      we    <= '0;
      waddr <= '0;
      wdata <= '0;
    end else if (alu_grant || mem_grant) begin
      we    <= (g_addr == '0) ? '0 : NREG'(1) << g_addr;
      waddr <= g_addr;
      wdata <= g_data;
    end else we <= '0;
endmodule

// File: tb/tb_irf_wr_arbiter.sv
// tb_irf_wr_arbiter: scoreboard bench with a timestamp-based reference model of the write arbiter
module tb_irf_wr_arbiter;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       alu_valid = 1'b0, mem_valid = 1'b0, hold = 1'b0;
  logic [2:0] alu_addr = '0, mem_addr = '0;
  logic [7:0] alu_data = '0, mem_data = '0;
  logic       alu_ready, mem_ready, busy;
  logic [7:0] we, wdata;
  logic [2:0] waddr;

  irf_wr_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .hold(hold), .we(we), .waddr(waddr), .wdata(wdata), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {logic [7:0] we; logic [2:0] a; logic [7:0] d; int c;} exp_t;
  typedef struct {bit v; bit [2:0] a; bit [7:0] d; int t;} ent_t;

  exp_t       q[$];
  ent_t       ms[2];
  int         rr_next = 0;
  int         cyc = 0;
  int         errs = 0, checks = 0;
  logic [7:0] rf_obs[8];
  int         log_q[$];
  bit         pa, pm;
  bit   [2:0] paa, pma;
  bit   [7:0] pad, pmd;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      chk("we_onehot", 32'($countones(we) <= 1), 1);
      if (we != 0) begin
        rf_obs[waddr] = wdata;
        log_q.push_back(int'(waddr));
        if (q.size() == 0) chk("unexpected_we", we, 0);
        else begin
          e = q.pop_front();
          chk("we", we, e.we);
          chk("waddr", waddr, e.a);
          chk("wdata", wdata, e.d);
          chk("we_cycle", cyc, e.c);
        end
      end else if (q.size() > 0 && q[0].c <= cyc) begin
        e = q.pop_front();
        chk("missing_we", we, e.we);
      end
    end
  end

  // One clock of stimulus; the model decides the winner from fill order and the RR turn.
  task automatic step(input bit av, input bit [2:0] aa, input bit [7:0] ad,
                      input bit mv, input bit [2:0] ma, input bit [7:0] md,
                      input bit h, output bit acc_a, output bit acc_m);
    int w;
    bit ra, rm;
    @(negedge clk);
    alu_valid = av; alu_addr = aa; alu_data = ad;
    mem_valid = mv; mem_addr = ma; mem_data = md;
    hold = h;
    #1;
    w = -1;
    if (!h) begin
      if (ms[0].v && ms[1].v) begin
        if (ms[0].a == ms[1].a) w = (ms[0].t < ms[1].t) ? 0 : 1;
        else begin
`ifdef IRF_WR_RR_EN
          w = rr_next;
          rr_next = 1 - w;
`else
          w = 1;
`endif
        end
      end else if (ms[0].v) w = 0;
      else if (ms[1].v) w = 1;
    end
    ra = !ms[0].v || w == 0;
    rm = !ms[1].v || w == 1;
    chk("alu_ready", alu_ready, ra);
    chk("mem_ready", mem_ready, rm);
    chk("busy", busy, ms[0].v || ms[1].v);
    if (w >= 0) begin
      if (ms[w].a != 0) q.push_back('{we: 8'd1 << ms[w].a, a: ms[w].a, d: ms[w].d, c: cyc + 1});
      ms[w].v = 0;
    end
    acc_a = av && ra;
    acc_m = mv && rm;
    if (acc_a) ms[0] = '{v: 1, a: aa, d: ad, t: cyc};
    if (acc_m) ms[1] = '{v: 1, a: ma, d: md, t: cyc};
  endtask

  task automatic idle(input int n);
    bit ka, km;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, ka, km);
  endtask

  task automatic run(input int n, input int hold_pct, input int req_pct);
    bit ka, km;
    for (int i = 0; i < n; i++) begin
      if (!pa && $urandom_range(0, 99) < req_pct) begin
        pa = 1; paa = 3'($urandom_range(0, 7)); pad = 8'($urandom);
      end
      if (!pm && $urandom_range(0, 99) < req_pct) begin
        pm = 1; pmd = 8'($urandom);
        pma = ($urandom_range(0, 2) == 0) ? paa : 3'($urandom_range(0, 7));
      end
      step(pa, paa, pad, pm, pma, pmd, $urandom_range(0, 99) < hold_pct, ka, km);
      if (ka) pa = 0;
      if (km) pm = 0;
    end
  endtask

  task automatic mid_reset();
    @(negedge clk);
    #2;
    alu_valid = 0; mem_valid = 0; hold = 0;
    rst_n = 0;
    #1;
    chk("rst_we", we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_ready", alu_ready, 1);
    chk("rst_mem_ready", mem_ready, 1);
    ms[0].v = 0; ms[1].v = 0; rr_next = 0; q.delete();
    pa = 0; pm = 0;
    @(posedge clk);
    #2;
    rst_n = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

  initial begin
    bit ka, km;
    #3;
    chk("reset_we", we, 0);
    chk("reset_waddr", waddr, 0);
    chk("reset_wdata", wdata, 0);
    chk("reset_alu_ready", alu_ready, 1);
    chk("reset_mem_ready", mem_ready, 1);
    chk("reset_busy", busy, 0);
    @(posedge clk);
    #2;
    rst_n = 1;

    step(1, 5, 8'h3C, 0, 0, 0, 0, ka, km);
    idle(3);
    chk("r5_value", rf_obs[5], 8'h3C);

    log_q.delete();
    step(1, 2, 8'h11, 1, 6, 8'h22, 0, ka, km);
    idle(4);
    chk("order_count", log_q.size(), 2);
`ifdef IRF_WR_RR_EN
    chk("order_first", log_q[0], 2);
    chk("order_second", log_q[1], 6);
`else
    chk("order_first", log_q[0], 6);
    chk("order_second", log_q[1], 2);
`endif

    step(1, 3, 8'hAA, 1, 3, 8'hBB, 0, ka, km);
    idle(4);
    chk("r3_final", rf_obs[3], 8'hAA);

    log_q.delete();
    step(0, 0, 0, 1, 0, 8'hFF, 0, ka, km);
    idle(3);
    chk("r0_no_we", log_q.size(), 0);
    chk("r0_mem_ready", mem_ready, 1);
    chk("r0_busy", busy, 0);

    run(4, 100, 100);
    chk("hold_alu_ready", alu_ready, 0);
    chk("hold_mem_ready", mem_ready, 0);
    run(10, 0, 100);
    run(8, 0, 0);

    step(1, 4, 8'h44, 1, 7, 8'h77, 1, ka, km);
    step(0, 0, 0, 0, 0, 0, 1, ka, km);
    mid_reset();
    idle(4);

    run(500, 12, 60);
    run(20, 0, 0);
    idle(3);
    chk("drain_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
